button_debounce: RTL and testbench

//   Input-side counterpart to the board LED drivers: reads one raw push-button pin.
//   - Synchronises and debounces the pin.
//   - Emits a clean level plus single-cycle press, release, long-press and auto-repeat events.
//   - Sits between the board button pin and user logic (LED toggles, mode select).

---
 rtl/button_debounce_pkg.sv | 31 +++
 rtl/button_debounce_sync_ff.sv | 33 +++
 rtl/button_debounce.sv | 187 ++++++++++++++++++
 tb/tb_button_debounce.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_debounce_pkg.sv
// Shared constants and types for the push-button debouncer.
//   CLK_HZ        board clock frequency the default timings are derived from
//   ms_to_cyc()   millisecond to sys_clk cycle conversion for parameter defaults
//   max3()        constant helper used to size the shared counter width
//   btn_evt_t     bundle of the single-cycle event pulses
package button_debounce_pkg;

    localparam int CLK_HZ = 27_000_000;

    function automatic int ms_to_cyc(input int ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    localparam int DEBOUNCE_CYC_DEF = ms_to_cyc(10);
    localparam int LONG_CYC_DEF     = ms_to_cyc(1000);
    localparam int REPEAT_CYC_DEF   = ms_to_cyc(200);

    typedef struct packed {
        logic press;
        logic rel;
        logic lng;
        logic rpt;
    } btn_evt_t;

endpackage

// File: rtl/button_debounce_sync_ff.sv
// sync_ff: STAGES-deep flop chain bringing an asynchronous pin into the clock domain.
//   clk   in  clock
//   rst   in  synchronous active-high reset, loads RESET_VAL into every stage
//   d     in  asynchronous input
//   q     out synchronised output (last stage)
module sync_ff #(
    parameter int STAGES    = 2,
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= {STAGES{RESET_VAL}};
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// button_debounce: synchronises and debounces one push-button pin and produces a
// clean level plus single-cycle press / release / long-press / auto-repeat events.
//   sys_clk      in   system clock
//   sys_rst      in   synchronous active-high reset
//   btn_in       in   raw asynchronous button pin
//   btn_level    out  debounced state, 1 = pressed
//   btn_press    out  1-cycle pulse on debounced press
//   btn_release  out  1-cycle pulse on debounced release
//   btn_long     out  1-cycle pulse when the hold reaches LONG_CYC
//   btn_repeat   out  1-cycle pulse every REPEAT_CYC after btn_long (0 disables)
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int LONG_CYC     = LONG_CYC_DEF,
    parameter int REPEAT_CYC   = REPEAT_CYC_DEF,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long,
    output logic btn_repeat
);

    localparam int CNT_MAX = max3(DEBOUNCE_CYC, LONG_CYC, REPEAT_CYC);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_SAT   = cnt_t'(CNT_MAX);
    localparam cnt_t DEB_LAST  = cnt_t'(DEBOUNCE_CYC - 1);
    localparam cnt_t LONG_LAST = cnt_t'(LONG_CYC - 1);
    localparam cnt_t REP_LAST  = cnt_t'((REPEAT_CYC > 0) ? REPEAT_CYC - 1 : 0);

    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        PRESSED,
        LONG,
        DEB_REL
    } state_t;

    function automatic cnt_t sat_inc(input cnt_t c);
        return (c == CNT_SAT) ? c : c + cnt_t'(1);
    endfunction

    logic     pin_sync;
    logic     raw_q,   raw_d;
    state_t   state_q, state_d;
    logic     ret_long_q, ret_long_d;   // state to resume if the release turns out to be a bounce
    cnt_t     dcnt_q,  dcnt_d;
    cnt_t     hcnt_q,  hcnt_d;
    cnt_t     rcnt_q,  rcnt_d;
    logic     level_q, level_d;
    btn_evt_t evt_q,   evt_d;

    // Reset value is the released pin level so a reset never looks like a press.
    sync_ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (ACTIVE_LOW)
    ) u_sync (
        .clk (sys_clk),
        .rst (sys_rst),
        .d   (btn_in),
        .q   (pin_sync)
    );

    // Polarity-corrected sample, registered so the FSM only sees a flop output.
    always_comb begin
        raw_d = pin_sync ^ ACTIVE_LOW;
    end

    always_comb begin
        state_d    = state_q;
        ret_long_d = ret_long_q;
        dcnt_d     = dcnt_q;
        hcnt_d     = hcnt_q;
        rcnt_d     = rcnt_q;
        level_d    = level_q;
        evt_d      = '0;

        case (state_q)
            IDLE: begin
                level_d = 1'b0;
                if (raw_q) begin
                    state_d = DEB_PRESS;
                    dcnt_d  = '0;
                end
            end

            DEB_PRESS: begin
                if (!raw_q) begin
                    state_d = IDLE;
                end else if (dcnt_q == DEB_LAST) begin
                    state_d     = PRESSED;
                    evt_d.press = 1'b1;
                    level_d     = 1'b1;
                    hcnt_d      = '0;
                end else begin
                    dcnt_d = sat_inc(dcnt_q);
                end
            end

            // Release is tested first so it wins over a simultaneous long-press.
            PRESSED: begin
                if (!raw_q) begin
                    state_d    = DEB_REL;
                    dcnt_d     = '0;
                    ret_long_d = 1'b0;
                end else if (hcnt_q == LONG_LAST) begin
                    state_d   = LONG;
                    evt_d.lng = 1'b1;
                    rcnt_d    = '0;
                end else begin
                    hcnt_d = sat_inc(hcnt_q);
                end
            end

            LONG: begin
                if (!raw_q) begin
                    state_d    = DEB_REL;
                    dcnt_d     = '0;
                    ret_long_d = 1'b1;
                end else if (REPEAT_CYC > 0) begin
                    if (rcnt_q == REP_LAST) begin
                        evt_d.rpt = 1'b1;
                        rcnt_d    = '0;
                    end else begin
                        rcnt_d = sat_inc(rcnt_q);
                    end
                end
            end

            // hcnt/rcnt are left untouched here, so a bounce only costs the frozen cycles.
            DEB_REL: begin
                if (raw_q) begin
                    state_d = ret_long_q ? LONG : PRESSED;
                end else if (dcnt_q == DEB_LAST) begin
                    state_d   = IDLE;
                    evt_d.rel = 1'b1;
                    level_d   = 1'b0;
                end else begin
                    dcnt_d = sat_inc(dcnt_q);
                end
            end

            default: begin
                state_d = IDLE;
                level_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            raw_q      <= 1'b0;
            state_q    <= IDLE;
            ret_long_q <= 1'b0;
            dcnt_q     <= '0;
            hcnt_q     <= '0;
            rcnt_q     <= '0;
            level_q    <= 1'b0;
            evt_q      <= '0;
        end else begin
            raw_q      <= raw_d;
            state_q    <= state_d;
            ret_long_q <= ret_long_d;
            dcnt_q     <= dcnt_d;
            hcnt_q     <= hcnt_d;
            rcnt_q     <= rcnt_d;
            level_q    <= level_d;
            evt_q      <= evt_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = evt_q.press;
    assign btn_release = evt_q.rel;
    assign btn_long    = evt_q.lng;
    assign btn_repeat  = evt_q.rpt;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce: two instances, an active-low one with
// repeat enabled and an active-high one with repeat disabled.
// Edge e of a scenario is the e-th rising edge after the stimulus is applied;
// outputs are sampled 1 time unit after each edge.
module tb_button_debounce;

    logic sys_clk;
    logic sys_rst;
    logic btn_in, btn_in2;
    logic lvl1, prs1, rel1, lng1, rpt1;
    logic lvl2, prs2, rel2, lng2, rpt2;

    int checks   = 0;
    int failures = 0;

    int r_press_n, r_press_at, r_rel_n, r_rel_at, r_long_n, r_long_at;
    int r_rep_n, r_rep_first, r_rep_last;
    int r_clash = 0;
    logic [127:0] lvl_hist, out_hist;

    button_debounce #(
        .SYNC_STAGES(2), .DEBOUNCE_CYC(4), .LONG_CYC(20), .REPEAT_CYC(5), .ACTIVE_LOW(1'b1)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .btn_in(btn_in),
        .btn_level(lvl1), .btn_press(prs1), .btn_release(rel1),
        .btn_long(lng1), .btn_repeat(rpt1)
    );

    button_debounce #(
        .SYNC_STAGES(2), .DEBOUNCE_CYC(4), .LONG_CYC(20), .REPEAT_CYC(0), .ACTIVE_LOW(1'b0)
    ) dut2 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .btn_in(btn_in2),
        .btn_level(lvl2), .btn_press(prs2), .btn_release(rel2),
        .btn_long(lng2), .btn_repeat(rpt2)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic rec_clear();
        r_press_n = 0; r_press_at = -1;
        r_rel_n = 0;   r_rel_at = -1;
        r_long_n = 0;  r_long_at = -1;
        r_rep_n = 0;   r_rep_first = -1; r_rep_last = -1;
        lvl_hist = '0; out_hist = '0;
    endtask

    // Advance one edge and record what the selected instance did after it.
    task automatic step(input int e, input bit sel2);
        logic lv, pr, rl, lg, rp;
        @(posedge sys_clk);
        #1;
        if (sel2) {lv, pr, rl, lg, rp} = {lvl2, prs2, rel2, lng2, rpt2};
        else      {lv, pr, rl, lg, rp} = {lvl1, prs1, rel1, lng1, rpt1};
        lvl_hist[e] = lv;
        out_hist[e] = lv | pr | rl | lg | rp;
        if (pr) begin r_press_n++; r_press_at = e; end
        if (rl) begin r_rel_n++;   r_rel_at = e;   end
        if (lg) begin r_long_n++;  r_long_at = e;  end
        if (rp) begin
            if (r_rep_n == 0) r_rep_first = e;
            r_rep_n++;
            r_rep_last = e;
        end
        if ((prs1 & rel1) | (lng1 & rpt1) | (prs2 & rel2) | (lng2 & rpt2)) r_clash++;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1; btn_in = 1'b1; btn_in2 = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        checks++;
        if ({lvl1, prs1, rel1, lng1, rpt1} !== 5'b0) begin
            failures++; $display("FAIL reset_out1 got=%b exp=00000", {lvl1, prs1, rel1, lng1, rpt1});
        end
        checks++;
        if ({lvl2, prs2, rel2, lng2, rpt2} !== 5'b0) begin
            failures++; $display("FAIL reset_out2 got=%b exp=00000", {lvl2, prs2, rel2, lng2, rpt2});
        end
        sys_rst = 1'b0;
        rec_clear();
        for (int e = 0; e < 10; e++) step(e, 1'b0);
        checks++;
        if (out_hist[9:0] !== 10'b0) begin
            failures++; $display("FAIL reset_idle got=%b exp=0", out_hist[9:0]);
        end
    endtask

    task automatic test_clean_press();
        rec_clear();
        btn_in = 1'b0;
        for (int e = 0; e < 13; e++) step(e, 1'b0);
        checks++;
        if (r_press_at !== 7) begin failures++; $display("FAIL press_at got=%0d exp=7", r_press_at); end
        checks++;
        if (r_press_n !== 1) begin failures++; $display("FAIL press_width got=%0d exp=1", r_press_n); end
        checks++;
        if (lvl_hist[7:6] !== 2'b10) begin
            failures++; $display("FAIL press_level got=%b exp=10", lvl_hist[7:6]);
        end
        rec_clear();
        btn_in = 1'b1;
        for (int e = 0; e < 13; e++) step(e, 1'b0);
        checks++;
        if (r_rel_at !== 7) begin failures++; $display("FAIL release_at got=%0d exp=7", r_rel_at); end
        checks++;
        if (r_rel_n !== 1) begin failures++; $display("FAIL release_width got=%0d exp=1", r_rel_n); end
        checks++;
        if (lvl_hist[7:6] !== 2'b01) begin
            failures++; $display("FAIL release_level got=%b exp=01", lvl_hist[7:6]);
        end
        checks++;
        if (r_press_n + r_long_n !== 0) begin
            failures++; $display("FAIL release_stray got=%0d exp=0", r_press_n + r_long_n);
        end
    endtask

    task automatic test_glitch();
        rec_clear();
        btn_in = 1'b0;
        for (int e = 0; e < 20; e++) begin
            step(e, 1'b0);
            if (e == 2) btn_in = 1'b1;
        end
        checks++;
        if (out_hist[19:0] !== 20'b0) begin
            failures++; $display("FAIL glitch_quiet got=%b exp=0", out_hist[19:0]);
        end
        // A clean press right after must see full latency, i.e. the FSM is back in IDLE.
        rec_clear();
        btn_in = 1'b0;
        for (int e = 0; e < 10; e++) step(e, 1'b0);
        checks++;
        if (r_press_at !== 7) begin failures++; $display("FAIL glitch_idle got=%0d exp=7", r_press_at); end
        btn_in = 1'b1;
        for (int e = 10; e < 22; e++) step(e, 1'b0);
        checks++;
        if (r_rel_at !== 17) begin failures++; $display("FAIL glitch_rel got=%0d exp=17", r_rel_at); end
    endtask

    task automatic test_long_hold();
        rec_clear();
        btn_in = 1'b0;
        for (int e = 0; e < 80; e++) begin
            step(e, 1'b0);
            if (e == 59) btn_in = 1'b1;
        end
        checks++;
        if (r_press_at !== 7) begin failures++; $display("FAIL long_press_at got=%0d exp=7", r_press_at); end
        checks++;
        if (r_long_at !== 27) begin failures++; $display("FAIL long_at got=%0d exp=27", r_long_at); end
        checks++;
        if (r_long_n !== 1) begin failures++; $display("FAIL long_count got=%0d exp=1", r_long_n); end
        checks++;
        if (r_rep_n !== 7) begin failures++; $display("FAIL repeat_count got=%0d exp=7", r_rep_n); end
        checks++;
        if (r_rep_first !== 32) begin failures++; $display("FAIL repeat_first got=%0d exp=32", r_rep_first); end
        checks++;
        if (r_rep_last !== 62) begin failures++; $display("FAIL repeat_last got=%0d exp=62", r_rep_last); end
        checks++;
        if (r_rel_at !== 67) begin failures++; $display("FAIL long_rel_at got=%0d exp=67", r_rel_at); end
        checks++;
        if (r_clash !== 0) begin failures++; $display("FAIL event_clash got=%0d exp=0", r_clash); end
    endtask

    task automatic test_release_bounce();
        rec_clear();
        btn_in = 1'b0;
        for (int e = 0; e < 50; e++) begin
            step(e, 1'b0);
            if (e == 9)  btn_in = 1'b1;
            if (e == 11) btn_in = 1'b0;
            if (e == 32) btn_in = 1'b1;
        end
        checks++;
        if (r_rel_at !== 40 || r_rel_n !== 1) begin
            failures++; $display("FAIL bounce_rel got=%0d/%0d exp=40/1", r_rel_at, r_rel_n);
        end
        checks++;
        if (&lvl_hist[39:7] !== 1'b1) begin
            failures++; $display("FAIL bounce_level got=%b exp=all1", lvl_hist[39:7]);
        end
        checks++;
        if (r_long_at !== 30) begin failures++; $display("FAIL bounce_long_at got=%0d exp=30", r_long_at); end
        checks++;
        if (r_rep_n !== 1 || r_rep_first !== 35) begin
            failures++; $display("FAIL bounce_repeat got=%0d@%0d exp=1@35", r_rep_n, r_rep_first);
        end
    endtask

    // Release seen on the same edge the hold counter would fire long-press.
    task automatic test_long_release_race();
        rec_clear();
        btn_in = 1'b0;
        for (int e = 0; e < 40; e++) begin
            step(e, 1'b0);
            if (e == 23) btn_in = 1'b1;
        end
        checks++;
        if (r_long_n !== 0) begin failures++; $display("FAIL race_long got=%0d exp=0", r_long_n); end
        checks++;
        if (r_rel_at !== 31) begin failures++; $display("FAIL race_rel_at got=%0d exp=31", r_rel_at); end
    endtask

    task automatic test_reset_mid_long();
        rec_clear();
        btn_in = 1'b0;
        for (int e = 0; e < 50; e++) begin
            step(e, 1'b0);
            if (e == 28) sys_rst = 1'b1;
            if (e == 29) sys_rst = 1'b0;
        end
        checks++;
        if (r_long_at !== 27) begin failures++; $display("FAIL rst_long_at got=%0d exp=27", r_long_at); end
        checks++;
        if (out_hist[29] !== 1'b0) begin failures++; $display("FAIL rst_outputs got=%b exp=0", out_hist[29]); end
        checks++;
        if (r_rel_n !== 0) begin failures++; $display("FAIL rst_no_release got=%0d exp=0", r_rel_n); end
        checks++;
        if (r_press_n !== 2 || r_press_at !== 37) begin
            failures++; $display("FAIL rst_repress got=%0d@%0d exp=2@37", r_press_n, r_press_at);
        end
        checks++;
        if (lvl_hist[37:36] !== 2'b10) begin
            failures++; $display("FAIL rst_level got=%b exp=10", lvl_hist[37:36]);
        end
        btn_in = 1'b1;
        for (int e = 50; e < 62; e++) step(e, 1'b0);
        checks++;
        if (r_rel_at !== 57) begin failures++; $display("FAIL rst_rel_at got=%0d exp=57", r_rel_at); end
    endtask

    task automatic test_active_high_no_repeat();
        rec_clear();
        btn_in2 = 1'b1;
        for (int e = 0; e < 60; e++) begin
            step(e, 1'b1);
            if (e == 39) btn_in2 = 1'b0;
        end
        checks++;
        if (r_press_at !== 7) begin failures++; $display("FAIL ah_press_at got=%0d exp=7", r_press_at); end
        checks++;
        if (r_long_at !== 27) begin failures++; $display("FAIL ah_long_at got=%0d exp=27", r_long_at); end
        checks++;
        if (r_rep_n !== 0) begin failures++; $display("FAIL ah_repeat got=%0d exp=0", r_rep_n); end
        checks++;
        if (r_rel_at !== 47) begin failures++; $display("FAIL ah_rel_at got=%0d exp=47", r_rel_at); end
        checks++;
        if (lvl_hist[47:46] !== 2'b01) begin
            failures++; $display("FAIL ah_level got=%b exp=01", lvl_hist[47:46]);
        end
        checks++;
        if (r_clash !== 0) begin failures++; $display("FAIL final_clash got=%0d exp=0", r_clash); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_long_hold();
        test_release_bounce();
        test_long_release_race();
        test_reset_mid_long();
        test_active_high_no_repeat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
